// File: rtl/magia_pkg.sv
// Shared MAGIA types: AXI4 L2 port widths, request/response bundles and encodings.
package magia_pkg;

    localparam int unsigned AXI_L2_ADDR_W = 32;
    localparam int unsigned AXI_L2_DATA_W = 64;
    localparam int unsigned AXI_L2_ID_W   = 4;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [AXI_L2_ID_W-1:0]   id;
        logic [AXI_L2_ADDR_W-1:0] addr;
        logic [7:0]               len;
        logic [2:0]               size;
        logic [1:0]               burst;
    } axi_l2_ax_t;

    typedef struct packed {
        logic [AXI_L2_DATA_W-1:0]   data;
        logic [AXI_L2_DATA_W/8-1:0] strb;
        logic                       last;
    } axi_l2_w_t;

    typedef struct packed {
        logic [AXI_L2_ID_W-1:0] id;
        logic [1:0]             resp;
    } axi_l2_b_t;

    typedef struct packed {
        logic [AXI_L2_ID_W-1:0]   id;
        logic [AXI_L2_DATA_W-1:0] data;
        logic [1:0]               resp;
        logic                     last;
    } axi_l2_r_t;

    typedef struct packed {
        axi_l2_ax_t aw;
        logic       aw_valid;
        axi_l2_w_t  w;
        logic       w_valid;
        logic       b_ready;
        axi_l2_ax_t ar;
        logic       ar_valid;
        logic       r_ready;
    } axi_l2_req_t;

    typedef struct packed {
        logic       aw_ready;
        logic       w_ready;
        axi_l2_b_t  b;
        logic       b_valid;
        logic       ar_ready;
        axi_l2_r_t  r;
        logic       r_valid;
    } axi_l2_rsp_t;

endpackage

// File: rtl/magia_l2_axi_responder.sv
// AXI4 L2 subordinate over a flop-array memory, one burst at a time (IDLE/WDATA/WRESP/RDATA).
// Latency: W/R beats start the cycle after the address handshake, B the cycle after wlast.
// Backpressure: B/R hold until ready; MAGIA_L2_RESP_STALL_EN adds LFSR stalls on the readies and rvalid.
module magia_l2_axi_responder #(
    parameter logic [31:0] BASE_ADDR = 32'hC000_0000,
    parameter int unsigned N_WORDS   = 4096,
    parameter int unsigned DATA_W    = magia_pkg::AXI_L2_DATA_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  magia_pkg::axi_l2_req_t axi_req_i,
    output magia_pkg::axi_l2_rsp_t axi_rsp_o,
    output logic                   busy_o
);
    import magia_pkg::*;

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(N_WORDS);

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    state_t                   state;
    logic                     prio_w;
    logic [AXI_L2_ID_W-1:0]   id_q;
    logic [31:0]              addr_q;
    logic [7:0]               len_q;
    logic [7:0]               beat_q;
    logic [2:0]               size_q;
    logic [1:0]               burst_q;
    logic [1:0]               resp_q;
    logic                     over_q;
    logic [DATA_W-1:0]        mem [N_WORDS];

    logic                     stall;
    logic                     r_gate;
    logic                     aw_rdy, ar_rdy, w_rdy, b_vld, r_vld;
    logic                     aw_hs, ar_hs, w_hs, r_hs;
    logic [31:0]              off;
    logic                     in_range;
    logic [IDX_W-1:0]         idx;
    logic [1:0]               beat_resp;
    logic [1:0]               w_acc;
    logic [31:0]              next_addr;
    logic                     mem_we;
    axi_l2_ax_t               ax;

`ifdef MAGIA_L2_RESP_STALL_EN
    logic [15:0] lfsr;
    logic        r_pend;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr   <= 16'hACE1;
            r_pend <= 1'b0;
        end else begin
            lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            r_pend <= r_vld & ~axi_req_i.r_ready;
        end
    end

    // An rvalid already shown to the mesh must not be withdrawn by a stall.
    assign stall  = lfsr[0];
    assign r_gate = ~lfsr[0] | r_pend;
`else
    assign stall  = 1'b0;
    assign r_gate = 1'b1;
`endif

    assign off       = addr_q - BASE_ADDR;
    assign in_range  = (addr_q >= BASE_ADDR) && ((off >> OFF_W) < 32'(N_WORDS));
    assign idx       = off[OFF_W +: IDX_W];
    assign beat_resp = (burst_q == AXI_BURST_WRAP) ? AXI_RESP_SLVERR :
                       !in_range                   ? AXI_RESP_DECERR : AXI_RESP_OKAY;
    assign next_addr = (burst_q == AXI_BURST_INCR) ? addr_q + (32'd1 << size_q) : addr_q;

    assign aw_rdy = !rst_i && state == IDLE && !stall && axi_req_i.aw_valid &&
                    (!axi_req_i.ar_valid || prio_w);
    assign ar_rdy = !rst_i && state == IDLE && !stall && axi_req_i.ar_valid &&
                    (!axi_req_i.aw_valid || !prio_w);
    assign w_rdy  = !rst_i && state == WDATA && !stall;
    assign b_vld  = !rst_i && state == WRESP;
    assign r_vld  = !rst_i && state == RDATA && r_gate;

    assign aw_hs  = aw_rdy;
    assign ar_hs  = ar_rdy;
    assign w_hs   = w_rdy && axi_req_i.w_valid;
    assign r_hs   = r_vld && axi_req_i.r_ready;
    assign mem_we = w_hs && !over_q && beat_resp == AXI_RESP_OKAY;
    assign ax     = aw_hs ? axi_req_i.aw : axi_req_i.ar;
    assign busy_o = !rst_i && state != IDLE;

    // Worst response seen so far; a wlast off the expected beat count escalates to SLVERR.
    always_comb begin
        w_acc = resp_q;
        if (!over_q && beat_resp > w_acc)
            w_acc = beat_resp;
        if (axi_req_i.w.last && (over_q || beat_q != len_q) && w_acc < AXI_RESP_SLVERR)
            w_acc = AXI_RESP_SLVERR;
    end

    always_comb begin
        axi_rsp_o          = '0;
        axi_rsp_o.aw_ready = aw_rdy;
        axi_rsp_o.ar_ready = ar_rdy;
        axi_rsp_o.w_ready  = w_rdy;
        axi_rsp_o.b_valid  = b_vld;
        axi_rsp_o.r_valid  = r_vld;
        if (b_vld) begin
            axi_rsp_o.b.id   = id_q;
            axi_rsp_o.b.resp = resp_q;
        end
        if (r_vld) begin
            axi_rsp_o.r.id   = id_q;
            axi_rsp_o.r.resp = beat_resp;
            axi_rsp_o.r.last = (beat_q == len_q);
            axi_rsp_o.r.data = (beat_resp == AXI_RESP_OKAY) ? mem[idx] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (axi_req_i.w.strb[b])
                    mem[idx][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            prio_w  <= 1'b1;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            size_q  <= '0;
            burst_q <= '0;
            resp_q  <= AXI_RESP_OKAY;
            over_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs || ar_hs) begin
                        id_q    <= ax.id;
                        addr_q  <= ax.addr & ~((32'd1 << ax.size) - 32'd1);
                        len_q   <= ax.len;
                        size_q  <= ax.size;
                        burst_q <= ax.burst;
                        beat_q  <= '0;
                        resp_q  <= AXI_RESP_OKAY;
                        over_q  <= 1'b0;
                        prio_w  <= !prio_w;
                        state   <= aw_hs ? WDATA : RDATA;
                    end
                end
                WDATA: begin
                    if (w_hs) begin
                        resp_q <= w_acc;
                        beat_q <= beat_q + 8'd1;
                        addr_q <= next_addr;
                        if (beat_q == len_q)
                            over_q <= 1'b1;
                        if (axi_req_i.w.last)
                            state <= WRESP;
                    end
                end
                WRESP: begin
                    if (axi_req_i.b_ready)
                        state <= IDLE;
                end
                RDATA: begin
                    if (r_hs) begin
                        addr_q <= next_addr;
                        beat_q <= beat_q + 8'd1;
                        if (beat_q == len_q)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_magia_l2_axi_responder.sv
// Directed bench for magia_l2_axi_responder: arbitration, INCR/FIXED/WRAP, strobes, decode edge, reset.
module tb_magia_l2_axi_responder;
    import magia_pkg::*;

    localparam logic [31:0] BASE = 32'hC000_0000;
    localparam logic [31:0] TOP  = BASE + 32'(4096 * 8) - 32'd8;

    logic        clk;
    logic        rst;
    logic        busy;
    axi_l2_req_t req;
    axi_l2_rsp_t rsp;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_d [4];
    logic [1:0]  exp_r [4];

    magia_l2_axi_responder dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .axi_req_i (req),
        .axi_rsp_o (rsp),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_aw(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bt,
                          input logic [3:0] id);
        req.aw.addr = a; req.aw.len = l; req.aw.size = 3'd3; req.aw.burst = bt; req.aw.id = id;
    endtask

    task automatic set_ar(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
        req.ar.addr = a; req.ar.len = l; req.ar.size = 3'd3; req.ar.burst = AXI_BURST_INCR;
        req.ar.id = id;
    endtask

    // Starts and ends at a negedge with the DUT in IDLE.
    task automatic do_write(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bt,
                            input logic [3:0] id, input logic [63:0] d0, input logic [7:0] st,
                            input int nb, input logic [1:0] er);
        set_aw(a, l, bt, id);
        req.aw_valid = 1'b1;
        #1 chk("wr_awready", 64'(rsp.aw_ready), 64'd1);
        @(negedge clk);
        req.aw_valid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            req.w.data = d0 + 64'(i); req.w.strb = st; req.w.last = (i == nb - 1);
            req.w_valid = 1'b1;
            #1 chk("wr_wready", 64'(rsp.w_ready), 64'd1);
            @(negedge clk);
        end
        req.w_valid = 1'b0;
        #1 chk("wr_bvalid", 64'(rsp.b_valid), 64'd1);
        chk("wr_bresp", 64'(rsp.b.resp), 64'(er));
        chk("wr_bid", 64'(rsp.b.id), 64'(id));
        @(negedge clk);
        #1 chk("wr_idle", 64'(busy), 64'd0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
        set_ar(a, l, id);
        req.ar_valid = 1'b1;
        #1 chk("rd_arready", 64'(rsp.ar_ready), 64'd1);
        @(negedge clk);
        req.ar_valid = 1'b0;
        for (int i = 0; i <= int'(l); i++) begin
            #1 chk("rd_rvalid", 64'(rsp.r_valid), 64'd1);
            chk("rd_rdata", rsp.r.data, exp_d[i]);
            chk("rd_rresp", 64'(rsp.r.resp), 64'(exp_r[i]));
            chk("rd_rlast", 64'(rsp.r.last), 64'(i == int'(l)));
            chk("rd_rid", 64'(rsp.r.id), 64'(id));
            @(negedge clk);
        end
        #1 chk("rd_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        req = '0;
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        rst = 1'b1;
        set_aw(BASE, 8'd3, AXI_BURST_INCR, 4'd5);
        set_ar(BASE, 8'd3, 4'd9);
        req.aw_valid = 1'b1;
        req.ar_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_awready", 64'(rsp.aw_ready), 64'd0);
        chk("rst_arready", 64'(rsp.ar_ready), 64'd0);
        chk("rst_wready", 64'(rsp.w_ready), 64'd0);
        chk("rst_bvalid", 64'(rsp.b_valid), 64'd0);
        chk("rst_rvalid", 64'(rsp.r_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rdata", rsp.r.data, 64'd0);

        // First IDLE after reset: write wins the tie.
        rst = 1'b0;
        #1 chk("arb0_awready", 64'(rsp.aw_ready), 64'd1);
        chk("arb0_arready", 64'(rsp.ar_ready), 64'd0);
        @(negedge clk);
        req.aw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req.w.data = 64'(i + 1); req.w.strb = 8'hFF; req.w.last = (i == 3);
            req.w_valid = 1'b1;
            #1 chk("w1_wready", 64'(rsp.w_ready), 64'd1);
            if (i == 0) begin
                chk("w1_arready_busy", 64'(rsp.ar_ready), 64'd0);
                chk("w1_busy", 64'(busy), 64'd1);
            end
            @(negedge clk);
        end
        req.w_valid = 1'b0;
        #1 chk("w1_bvalid", 64'(rsp.b_valid), 64'd1);
        chk("w1_bid", 64'(rsp.b.id), 64'd5);
        chk("w1_bresp", 64'(rsp.b.resp), 64'(AXI_RESP_OKAY));
        @(negedge clk);

        // Next IDLE: read wins over a new write.
        set_aw(BASE + 32'd80, 8'd0, AXI_BURST_INCR, 4'd6);
        req.aw_valid = 1'b1;
        #1 chk("arb1_arready", 64'(rsp.ar_ready), 64'd1);
        chk("arb1_awready", 64'(rsp.aw_ready), 64'd0);
        @(negedge clk);
        req.ar_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("r1_rvalid", 64'(rsp.r_valid), 64'd1);
            chk("r1_rdata", rsp.r.data, 64'(i + 1));
            chk("r1_rlast", 64'(rsp.r.last), 64'(i == 3));
            chk("r1_rid", 64'(rsp.r.id), 64'd9);
            if (i == 0) chk("r1_awready", 64'(rsp.aw_ready), 64'd0);
            @(negedge clk);
        end

        // Both valid again: write wins.
        req.ar_valid = 1'b1;
        #1 chk("arb2_awready", 64'(rsp.aw_ready), 64'd1);
        chk("arb2_arready", 64'(rsp.ar_ready), 64'd0);
        @(negedge clk);
        req.ar_valid = 1'b0;
        req.aw_valid = 1'b0;
        req.w.data = 64'd0; req.w.strb = 8'hFF; req.w.last = 1'b1; req.w_valid = 1'b1;
        @(negedge clk);
        req.w_valid = 1'b0;
        #1 chk("w2_bvalid", 64'(rsp.b_valid), 64'd1);
        chk("w2_bid", 64'(rsp.b.id), 64'd6);
        @(negedge clk);

        // Partial strobe over a zero word.
        do_write(BASE + 32'd80, 8'd0, AXI_BURST_INCR, 4'd1, '1, 8'h0F, 1, AXI_RESP_OKAY);
        exp_d[0] = 64'h0000_0000_FFFF_FFFF; exp_r[0] = AXI_RESP_OKAY;
        do_read(BASE + 32'd80, 8'd0, 4'd1);

        // Read crossing the top edge.
        do_write(TOP, 8'd0, AXI_BURST_INCR, 4'd2, 64'hDEAD_BEEF_0123_4567, 8'hFF, 1, AXI_RESP_OKAY);
        exp_d[0] = 64'hDEAD_BEEF_0123_4567; exp_r[0] = AXI_RESP_OKAY;
        exp_d[1] = 64'd0;                   exp_r[1] = AXI_RESP_DECERR;
        do_read(TOP, 8'd1, 4'd2);

        // WRAP write: SLVERR, memory untouched.
        do_write(BASE, 8'd1, AXI_BURST_WRAP, 4'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 2,
                 AXI_RESP_SLVERR);
        exp_d[0] = 64'd1; exp_r[0] = AXI_RESP_OKAY;
        do_read(BASE, 8'd0, 4'd3);

        // Early wlast: SLVERR, the beats received are still written.
        do_write(BASE + 32'd16, 8'd3, AXI_BURST_INCR, 4'd4, 64'h50, 8'hFF, 2, AXI_RESP_SLVERR);
        exp_d[0] = 64'h50; exp_r[0] = AXI_RESP_OKAY;
        exp_d[1] = 64'h51; exp_r[1] = AXI_RESP_OKAY;
        do_read(BASE + 32'd16, 8'd1, 4'd4);

        // Below BASE: DECERR.
        do_write(BASE - 32'd8, 8'd0, AXI_BURST_INCR, 4'd7, 64'h1, 8'hFF, 1, AXI_RESP_DECERR);

        // Extra beats past len: SLVERR, only beat 0 lands.
        do_write(BASE + 32'd200, 8'd0, AXI_BURST_INCR, 4'd8, 64'h70, 8'hFF, 3, AXI_RESP_SLVERR);
        exp_d[0] = 64'h70; exp_r[0] = AXI_RESP_OKAY;
        do_read(BASE + 32'd200, 8'd0, 4'd8);

        // FIXED burst at an unaligned address: both beats hit the aligned word.
        do_write(BASE + 32'h104, 8'd1, AXI_BURST_FIXED, 4'd10, 64'h60, 8'hFF, 2, AXI_RESP_OKAY);
        exp_d[0] = 64'h61; exp_r[0] = AXI_RESP_OKAY;
        do_read(BASE + 32'h100, 8'd0, 4'd10);

        // rdata holds under rready=0, then reset mid-read.
        req.r_ready = 1'b0;
        set_ar(BASE, 8'd3, 4'd2);
        req.ar_valid = 1'b1;
        @(negedge clk);
        req.ar_valid = 1'b0;
        #1 chk("hold_rvalid0", 64'(rsp.r_valid), 64'd1);
        chk("hold_rdata0", rsp.r.data, 64'd1);
        @(negedge clk);
        #1 chk("hold_rvalid1", 64'(rsp.r_valid), 64'd1);
        chk("hold_rdata1", rsp.r.data, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        #1 chk("mid_rst_rvalid", 64'(rsp.r_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_rid", 64'(rsp.r.id), 64'd0);
        rst = 1'b0;
        req.r_ready = 1'b1;
        #1 chk("post_rst_rvalid", 64'(rsp.r_valid), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        set_aw(BASE, 8'd0, AXI_BURST_INCR, 4'd1);
        req.aw_valid = 1'b1;
        req.ar_valid = 1'b1;
        #1 chk("post_rst_awready", 64'(rsp.aw_ready), 64'd1);
        chk("post_rst_arready", 64'(rsp.ar_ready), 64'd0);
        req.aw_valid = 1'b0;
        req.ar_valid = 1'b0;
        exp_d[0] = 64'd1; exp_r[0] = AXI_RESP_OKAY;
        do_read(BASE, 8'd0, 4'd11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
